// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation encoding and
// helpers that classify operations by latency class.
// Optional feature: define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
package md_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } md_op_t;

  // Operations that occupy the unit for MULT_CYCLES.
  function automatic logic is_mult(md_op_t op);
`ifdef MD_MADD_EN
    return (op == OP_MULT)  || (op == OP_MULTU) ||
           (op == OP_MADD)  || (op == OP_MADDU) ||
           (op == OP_MSUB)  || (op == OP_MSUBU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  // Operations that occupy the unit for DIV_CYCLES.
  function automatic logic is_div(md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result generator for the multiply/divide unit.
// Result layout is {hi, lo}. Divides return {remainder, quotient}; a divide
// by zero returns the incoming {hi, lo} so the commit leaves them unchanged.
// Optional feature: MD_MADD_EN adds accumulate/subtract-from-{hi,lo} ops.
module md_calc
  import md_pkg::*;
(
  input  md_op_t      i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [63:0] o_res
);

  logic        w_sgn;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [63:0] w_prod;
  logic        w_rs_neg;
  logic        w_rt_neg;
  logic [31:0] w_rs_mag;
  logic [31:0] w_rt_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;

  assign w_sgn = (i_op == OP_MULT) || (i_op == OP_DIV) ||
                 (i_op == OP_MADD) || (i_op == OP_MSUB);

  // Low 64 bits of a 64x64 product of extended operands are the exact
  // 32x32 product, signed or unsigned depending on the extension.
  assign w_prod_s = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
  assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};
  assign w_prod   = w_sgn ? w_prod_s : w_prod_u;

  // Signed divide is done on magnitudes so 0x80000000 / -1 yields
  // 0x80000000 without relying on overflow behaviour of a signed divide.
  assign w_rs_neg = w_sgn & i_rs[31];
  assign w_rt_neg = w_sgn & i_rt[31];
  assign w_rs_mag = w_rs_neg ? (32'd0 - i_rs) : i_rs;
  assign w_rt_mag = w_rt_neg ? (32'd0 - i_rt) : i_rt;
  assign w_q_mag  = (w_rt_mag == 32'd0) ? 32'd0 : (w_rs_mag / w_rt_mag);
  assign w_r_mag  = (w_rt_mag == 32'd0) ? 32'd0 : (w_rs_mag % w_rt_mag);
  assign w_q      = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r      = w_rs_neg ? (32'd0 - w_r_mag) : w_r_mag;

  // Select the {hi, lo} result for the requested operation.
  always_comb begin
    o_res = {i_hi, i_lo};
    case (i_op)
      OP_MULT, OP_MULTU: o_res = w_prod;
      OP_DIV, OP_DIVU:   o_res = (i_rt == 32'd0) ? {i_hi, i_lo} : {w_r, w_q};
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU: o_res = {i_hi, i_lo} + w_prod;
      OP_MSUB, OP_MSUBU: o_res = {i_hi, i_lo} - w_prod;
`endif
      default:           o_res = {i_hi, i_lo};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs multi-cycle ops with a
// fixed latency, and services MTHI/MTLO/MFHI/MFLO.
// Optional feature: MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU (MULT latency);
// without it those codes are no-ops.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
)(
  input  logic        clk,
  input  logic        reset_n,
  input  md_op_t      md_op,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;

  logic             w_accept;
  logic             w_load;
  logic [63:0]      w_res;

  assign w_accept = start & ~cancel & (r_state == S_IDLE);
  assign w_load   = w_accept & (is_mult(md_op) | is_div(md_op));

  md_calc u_calc (
    .i_op  (md_op),
    .i_rs  (rs_val),
    .i_rt  (rt_val),
    .i_hi  (r_hi),
    .i_lo  (r_lo),
    .o_res (w_res)
  );

  // Capture the result at accept; it is only committed when the run ends.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_pend_hi <= w_res[63:32];
      r_pend_lo <= w_res[31:0];
    end
  end

  // Control FSM: accept ops, count out the latency, commit HI/LO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        if (md_op == OP_MTHI) begin
          r_hi <= rs_val;
        end else if (md_op == OP_MTLO) begin
          r_lo <= rs_val;
        end else if (w_load) begin
          r_count <= is_div(md_op) ? DIV_LAST : MULT_LAST;
          r_state <= S_RUN;
          r_busy  <= 1'b1;
        end
      end
    end else begin
      if (r_count == '0) begin
        r_hi    <= r_pend_hi;
        r_lo    <= r_pend_lo;
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // MFHI/MFLO read path, independent of busy (the hazard unit stalls reads).
  always_comb begin
    md_out = 32'd0;
    if (md_op == OP_MFHI)      md_out = r_hi;
    else if (md_op == OP_MFLO) md_out = r_lo;
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
